// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between N_REQ requesters.
// Operands are registered into the ALU; the result is returned with the owner's ID.
module alu_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_opA,
  input  logic [N_REQ*W-1:0] req_opB,
  input  logic [N_REQ*W-1:0] req_opSel,
  output logic [W-1:0]       alu_opA,
  output logic [W-1:0]       alu_opB,
  output logic [W-1:0]       alu_opSel,
  input  logic [W-1:0]       alu_out,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [W-1:0]       resp_data,
  output logic [IDW-1:0]     resp_id,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] cand;
  logic           win_found;
  logic           accept;
  logic [W-1:0]   win_opA, win_opB, win_opSel;

  // Modulo add done by compare/subtract so non-power-of-two N_REQ wraps correctly.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return IDW'(sum);
  endfunction

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = wrap_idx(rr_ptr, k);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    win_opA   = '0;
    win_opB   = '0;
    win_opSel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (IDW'(i) == win_id) begin
        win_opA   = req_opA[i*W +: W];
        win_opB   = req_opB[i*W +: W];
        win_opSel = req_opSel[i*W +: W];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    accept     = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          req_ready[win_id] = 1'b1;
          accept            = 1'b1;
          state_nxt         = EXEC;
        end
      end
      EXEC: begin
        busy      = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      alu_opA   <= '0;
      alu_opB   <= '0;
      alu_opSel <= '0;
      resp_data <= '0;
      resp_id   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_opA   <= win_opA;
        alu_opB   <= win_opB;
        alu_opSel <= win_opSel;
        grant_id  <= win_id;
      end
      if (state == EXEC) begin
        resp_data <= alu_out;
        resp_id   <= grant_id;
      end
      // Just-served requester drops to lowest priority for the next arbitration.
      if (state == RESP && resp_ready)
        rr_ptr <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule
